audio_ram_streamer: RTL and testbench

AUDIO_RAM_STREAMER -- requirements
Module: audio_ram_streamer

---
 rtl/audio_ram_streamer_if.sv | 38 +++
 rtl/audio_ram_streamer.sv | 163 ++++++++++++++++
 tb/tb_audio_ram_streamer.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/audio_ram_streamer_if.sv
// ============================================================================
//  Module      : audio_ram_streamer_if
//  Description : CSR, sample-RAM read port and sample stream for the streamer.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface audio_ram_streamer_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
);
    logic [1:0]        csr_address;
    logic              csr_write;
    logic              csr_read;
    logic [31:0]       csr_writedata;
    logic [31:0]       csr_readdata;
    logic [ADDR_W-1:0] ram_address;
    logic              ram_chipselect;
    logic              ram_write;
    logic [DATA_W-1:0] ram_readdata;
    logic [DATA_W-1:0] src_data;
    logic              src_valid;
    logic              src_ready;
    logic              irq;

    // master is the streamer itself; slave is the host / RAM / codec side
    modport master (
        input  csr_address, csr_write, csr_read, csr_writedata, ram_readdata, src_ready,
        output csr_readdata, ram_address, ram_chipselect, ram_write, src_data, src_valid, irq
    );

    modport slave (
        output csr_address, csr_write, csr_read, csr_writedata, ram_readdata, src_ready,
        input  csr_readdata, ram_address, ram_chipselect, ram_write, src_data, src_valid, irq
    );
endinterface

`default_nettype wire

// File: rtl/audio_ram_streamer.sv
// ============================================================================
//  Module      : audio_ram_streamer
//  Description : Streams a block of words from sample RAM to a codec FIFO.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module audio_ram_streamer #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    audio_ram_streamer_if.master bus
);
    localparam logic [1:0]        c_reg_ctrl   = 2'd0;
    localparam logic [1:0]        c_reg_base   = 2'd1;
    localparam logic [1:0]        c_reg_length = 2'd2;
    localparam logic [1:0]        c_reg_status = 2'd3;
    localparam logic [ADDR_W:0]   c_len_zero   = '0;
    localparam logic [ADDR_W:0]   c_len_one    = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] c_ptr_one    = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        PRESENT = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_run;
    logic              r_loop;
    logic              r_irq_en;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W:0]   r_length;
    logic              r_done;
    logic              r_cfg_err;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   r_remaining;
    logic [DATA_W-1:0] r_src_data;
    logic              r_src_valid;
    logic              r_ram_cs;
    logic [ADDR_W-1:0] r_ram_address;

    logic              w_busy;
    logic [ADDR_W-1:0] w_ptr_inc;
    logic [31:0]       w_readmux;
    logic              w_unused;

    assign w_busy    = (r_state != IDLE);
    assign w_ptr_inc = r_ptr + c_ptr_one;
    assign w_unused  = ^bus.csr_writedata[31:ADDR_W+1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_run         <= 1'b0;
            r_loop        <= 1'b0;
            r_irq_en      <= 1'b0;
            r_base        <= '0;
            r_length      <= '0;
            r_done        <= 1'b0;
            r_cfg_err     <= 1'b0;
            r_ptr         <= '0;
            r_remaining   <= '0;
            r_src_data    <= '0;
            r_src_valid   <= 1'b0;
            r_ram_cs      <= 1'b0;
            r_ram_address <= '0;
        end else begin
            r_ram_cs <= 1'b0;

            if (bus.csr_write) begin
                case (bus.csr_address)
                    c_reg_ctrl: begin
                        r_run    <= bus.csr_writedata[0];
                        r_loop   <= bus.csr_writedata[1];
                        r_irq_en <= bus.csr_writedata[2];
                        if ((r_state == IDLE) && bus.csr_writedata[0]) begin
                            if (r_length == c_len_zero) begin
                                r_cfg_err <= 1'b1;
                                r_run     <= 1'b0;
                            end else begin
                                r_state       <= ISSUE;
                                r_ptr         <= r_base;
                                r_remaining   <= r_length;
                                r_ram_cs      <= 1'b1;
                                r_ram_address <= r_base;
                            end
                        end
                    end
                    c_reg_base: begin
                        if (!w_busy) r_base <= bus.csr_writedata[ADDR_W-1:0];
                    end
                    c_reg_length: begin
                        if (!w_busy) r_length <= bus.csr_writedata[ADDR_W:0];
                    end
                    default: begin
                        if (bus.csr_writedata[1]) r_done    <= 1'b0;
                        if (bus.csr_writedata[2]) r_cfg_err <= 1'b0;
                    end
                endcase
            end

            // Internal updates come after the CSR decode so a same-cycle done-set beats W1C
            case (r_state)
                ISSUE: r_state <= CAPTURE;
                CAPTURE: begin
                    r_src_data  <= bus.ram_readdata;
                    r_src_valid <= 1'b1;
                    r_state     <= PRESENT;
                end
                PRESENT: begin
                    if (bus.src_ready) begin
                        r_src_valid <= 1'b0;
                        r_ptr       <= w_ptr_inc;
                        r_remaining <= r_remaining - c_len_one;
                        if (!r_run) begin
                            r_state <= IDLE;
                        end else if (r_remaining > c_len_one) begin
                            r_state       <= ISSUE;
                            r_ram_cs      <= 1'b1;
                            r_ram_address <= w_ptr_inc;
                        end else if (r_loop) begin
                            r_state       <= ISSUE;
                            r_ptr         <= r_base;
                            r_remaining   <= r_length;
                            r_ram_cs      <= 1'b1;
                            r_ram_address <= r_base;
                        end else begin
                            r_done  <= 1'b1;
                            r_run   <= 1'b0;
                            r_state <= IDLE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_readmux = 32'd0;
        case (bus.csr_address)
            c_reg_ctrl:   w_readmux = {29'd0, r_irq_en, r_loop, r_run};
            c_reg_base:   w_readmux = {{(32-ADDR_W){1'b0}}, r_base};
            c_reg_length: w_readmux = {{(31-ADDR_W){1'b0}}, r_length};
            default:      w_readmux = {29'd0, r_cfg_err, r_done, w_busy};
        endcase
    end

    assign bus.csr_readdata   = bus.csr_read ? w_readmux : 32'd0;
    assign bus.ram_address    = r_ram_address;
    assign bus.ram_chipselect = r_ram_cs;
    assign bus.ram_write      = 1'b0;
    assign bus.src_data       = r_src_data;
    assign bus.src_valid      = r_src_valid;
    assign bus.irq            = r_done & r_irq_en;

endmodule

`default_nettype wire

// File: tb/tb_audio_ram_streamer.sv
// ============================================================================
//  Module      : tb_audio_ram_streamer
//  Description : Self-checking bench for audio_ram_streamer.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_audio_ram_streamer;
    localparam int AW    = 11;
    localparam int DW    = 32;
    localparam int DEPTH = 2048;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    audio_ram_streamer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    audio_ram_streamer #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [31:0] mem [0:DEPTH-1];
    logic [31:0] rd_q = 32'd0;
    assign bus.ram_readdata = rd_q;
    always @(posedge clk) if (bus.ram_chipselect) rd_q <= mem[bus.ram_address];

    int          addr_log[$];
    logic [31:0] xfer_log[$];
    int          viol = 0;
    logic        pend = 1'b0;
    logic [31:0] pdata = 32'd0;

    // Monitor: RAM reads, stream transfers, and valid/data stability while stalled
    always @(posedge clk) begin
        if (bus.ram_chipselect) addr_log.push_back(int'(bus.ram_address));
        if (bus.src_valid && bus.src_ready) xfer_log.push_back(bus.src_data);
        if (reset_n && pend && (!bus.src_valid || bus.src_data !== pdata)) viol++;
        pend  = reset_n && bus.src_valid && !bus.src_ready;
        pdata = bus.src_data;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
        bus.csr_address   = a;
        bus.csr_writedata = d;
        bus.csr_write     = 1'b1;
        @(negedge clk);
        bus.csr_write     = 1'b0;
    endtask

    task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
        bus.csr_address = a;
        bus.csr_read    = 1'b1;
        #1;
        d = bus.csr_readdata;
        bus.csr_read    = 1'b0;
    endtask

    task automatic wait_valid(input int bound, input string name);
        int n = 0;
        while (!bus.src_valid && n < bound) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(bus.src_valid), 32'd1);
    endtask

    task automatic drain(input int bound, input bit rnd, input string name);
        logic [31:0] s;
        int n = 0;
        csr_rd(2'd3, s);
        while (s[0] && n < bound) begin
            bus.src_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            n++;
            csr_rd(2'd3, s);
        end
        bus.src_ready = 1'b0;
        check(name, 32'(s[0]), 32'd0);
    endtask

    typedef struct {
        int         base;
        int         length;
        logic [2:0] ctrl;
        bit         rnd;
        logic [2:0] exp_status;
        logic       exp_irq;
    } vec_t;

    vec_t        vt [8];
    logic [31:0] rd;
    logic [31:0] d0;
    int          n0;
    bit          stable;

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        bus.csr_address = 2'd0; bus.csr_write = 1'b0; bus.csr_read = 1'b0;
        bus.csr_writedata = 32'd0; bus.src_ready = 1'b0;

        vt[0] = '{10,   3,  3'b001, 1'b0, 3'b010, 1'b0};
        vt[1] = '{2046, 4,  3'b001, 1'b0, 3'b010, 1'b0};
        vt[2] = '{0,    1,  3'b101, 1'b1, 3'b010, 1'b1};
        vt[3] = '{2040, 12, 3'b101, 1'b1, 3'b010, 1'b1};
        for (int i = 4; i < 8; i++) begin
            vt[i].base       = int'($urandom_range(0, DEPTH - 1));
            vt[i].length     = int'($urandom_range(1, 16));
            vt[i].ctrl       = {1'($urandom_range(0, 1)), 2'b01};
            vt[i].rnd        = 1'b1;
            vt[i].exp_status = 3'b010;
            vt[i].exp_irq    = vt[i].ctrl[2];
        end

        // Reset state
        repeat (3) @(negedge clk);
        check("rst chipselect", 32'(bus.ram_chipselect), 32'd0);
        check("rst src_valid", 32'(bus.src_valid), 32'd0);
        check("rst irq", 32'(bus.irq), 32'd0);
        check("rst ram_write", 32'(bus.ram_write), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        for (int r = 0; r < 4; r++) begin
            csr_rd(2'(r), rd);
            check($sformatf("rst reg%0d", r), rd, 32'd0);
        end
        repeat (5) @(negedge clk);
        check("no access after reset", 32'(addr_log.size()), 32'd0);

        // Latency: first valid three cycles after the run write
        csr_wr(2'd1, 32'd10);
        csr_wr(2'd2, 32'd3);
        bus.src_ready = 1'b1;
        csr_wr(2'd0, 32'd1);
        check("lat issue cs", 32'(bus.ram_chipselect), 32'd1);
        check("lat issue addr", 32'(bus.ram_address), 32'd10);
        check("lat issue valid", 32'(bus.src_valid), 32'd0);
        @(negedge clk);
        check("lat capture cs", 32'(bus.ram_chipselect), 32'd0);
        check("lat capture valid", 32'(bus.src_valid), 32'd0);
        @(negedge clk);
        check("lat present valid", 32'(bus.src_valid), 32'd1);
        check("lat present data", bus.src_data, mem[10]);
        @(negedge clk);
        check("lat second issue addr", 32'(bus.ram_address), 32'd11);
        check("lat second issue cs", 32'(bus.ram_chipselect), 32'd1);
        drain(200, 1'b0, "lat drain");

        // Table-driven one-shot runs against the address/data model
        for (int v = 0; v < 8; v++) begin
            csr_wr(2'd3, 32'd6);
            csr_wr(2'd1, 32'(vt[v].base));
            csr_wr(2'd2, 32'(vt[v].length));
            addr_log.delete();
            xfer_log.delete();
            viol = 0;
            csr_wr(2'd0, 32'(vt[v].ctrl));
            drain(3000, vt[v].rnd, $sformatf("vec%0d idle", v));
            check($sformatf("vec%0d reads", v), 32'(addr_log.size()), 32'(vt[v].length));
            check($sformatf("vec%0d transfers", v), 32'(xfer_log.size()), 32'(vt[v].length));
            for (int k = 0; k < vt[v].length && k < addr_log.size() && k < xfer_log.size(); k++) begin
                int a;
                a = (vt[v].base + k) % DEPTH;
                check($sformatf("vec%0d addr%0d", v, k), 32'(addr_log[k]), 32'(a));
                check($sformatf("vec%0d data%0d", v, k), xfer_log[k], mem[a]);
            end
            csr_rd(2'd3, rd);
            check($sformatf("vec%0d status", v), rd, 32'(vt[v].exp_status));
            csr_rd(2'd0, rd);
            check($sformatf("vec%0d ctrl", v), rd, 32'(vt[v].ctrl & 3'b110));
            check($sformatf("vec%0d irq", v), 32'(bus.irq), 32'(vt[v].exp_irq));
            check($sformatf("vec%0d stability", v), 32'(viol), 32'd0);
        end

        // Loop mode then stop while a sample is held
        csr_wr(2'd3, 32'd6);
        csr_wr(2'd1, 32'd5);
        csr_wr(2'd2, 32'd2);
        addr_log.delete();
        xfer_log.delete();
        bus.src_ready = 1'b1;
        csr_wr(2'd0, 32'd3);
        repeat (20) @(negedge clk);
        bus.src_ready = 1'b0;
        wait_valid(10, "loop held valid");
        csr_wr(2'd0, 32'd0);
        check("loop still valid", 32'(bus.src_valid), 32'd1);
        bus.src_ready = 1'b1;
        repeat (10) @(negedge clk);
        bus.src_ready = 1'b0;
        csr_rd(2'd3, rd);
        check("loop stop status", rd, 32'd0);
        check("loop pending delivered", 32'(xfer_log.size()), 32'(addr_log.size()));
        check("loop enough reads", 32'(addr_log.size() >= 6), 32'd1);
        for (int k = 0; k < addr_log.size() && k < xfer_log.size(); k++) begin
            check($sformatf("loop addr%0d", k), 32'(addr_log[k]), (k % 2 == 0) ? 32'd5 : 32'd6);
            check($sformatf("loop data%0d", k), xfer_log[k], mem[(k % 2 == 0) ? 5 : 6]);
        end

        // Backpressure: 20 stalled cycles then exactly one transfer
        csr_wr(2'd1, 32'd100);
        csr_wr(2'd2, 32'd5);
        addr_log.delete();
        xfer_log.delete();
        csr_wr(2'd0, 32'd1);
        wait_valid(10, "stall valid");
        d0 = bus.src_data;
        n0 = addr_log.size();
        check("stall data", d0, mem[100]);
        stable = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (!bus.src_valid || bus.src_data !== d0) stable = 1'b0;
        end
        check("stall stable", 32'(stable), 32'd1);
        check("stall no new read", 32'(addr_log.size()), 32'(n0));
        bus.src_ready = 1'b1;
        @(negedge clk);
        bus.src_ready = 1'b0;
        repeat (6) @(negedge clk);
        check("stall one transfer", 32'(xfer_log.size()), 32'd1);
        check("stall next data", bus.src_data, mem[101]);
        drain(200, 1'b0, "stall drain");

        // done-set in the same cycle as W1C done: set wins
        csr_wr(2'd3, 32'd6);
        csr_wr(2'd1, 32'd7);
        csr_wr(2'd2, 32'd1);
        csr_wr(2'd0, 32'd1);
        wait_valid(10, "setwin valid");
        bus.src_ready = 1'b1;
        csr_wr(2'd3, 32'd2);
        bus.src_ready = 1'b0;
        csr_rd(2'd3, rd);
        check("setwin status", rd, 32'd2);
        check("irq off without enable", 32'(bus.irq), 32'd0);
        csr_wr(2'd0, 32'd4);
        check("irq on", 32'(bus.irq), 32'd1);
        csr_wr(2'd3, 32'd2);
        check("irq cleared", 32'(bus.irq), 32'd0);

        // Zero length configuration error
        csr_wr(2'd2, 32'd0);
        n0 = addr_log.size();
        csr_wr(2'd0, 32'd1);
        csr_rd(2'd3, rd);
        check("cfg_err status", rd, 32'd4);
        csr_rd(2'd0, rd);
        check("cfg_err run cleared", rd, 32'd0);
        repeat (5) @(negedge clk);
        check("cfg_err no read", 32'(addr_log.size()), 32'(n0));
        csr_wr(2'd3, 32'd4);
        csr_rd(2'd3, rd);
        check("cfg_err cleared", rd, 32'd0);

        // BASE/LENGTH writes ignored while busy
        csr_wr(2'd1, 32'd20);
        csr_wr(2'd2, 32'd3);
        addr_log.delete();
        csr_wr(2'd0, 32'd1);
        csr_wr(2'd1, 32'd99);
        csr_wr(2'd2, 32'd7);
        csr_rd(2'd1, rd);
        check("busy base kept", rd, 32'd20);
        csr_rd(2'd2, rd);
        check("busy length kept", rd, 32'd3);
        drain(200, 1'b0, "busy drain");
        check("busy reads", 32'(addr_log.size()), 32'd3);
        for (int k = 0; k < 3 && k < addr_log.size(); k++)
            check($sformatf("busy addr%0d", k), 32'(addr_log[k]), 32'(20 + k));

        // Asynchronous reset while in CAPTURE
        bus.src_ready = 1'b1;
        csr_wr(2'd0, 32'd5);
        @(negedge clk);
        check("pre-reset irq", 32'(bus.irq), 32'd1);
        check("pre-reset capture cs", 32'(bus.ram_chipselect), 32'd0);
        reset_n = 1'b0;
        #1;
        check("async rst cs", 32'(bus.ram_chipselect), 32'd0);
        check("async rst valid", 32'(bus.src_valid), 32'd0);
        check("async rst irq", 32'(bus.irq), 32'd0);
        check("async rst data", bus.src_data, 32'd0);
        check("async rst addr", 32'(bus.ram_address), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        addr_log.delete();
        @(negedge clk);
        for (int r = 0; r < 4; r++) begin
            csr_rd(2'(r), rd);
            check($sformatf("post-rst reg%0d", r), rd, 32'd0);
        end
        repeat (8) @(negedge clk);
        check("post-rst no read", 32'(addr_log.size()), 32'd0);
        check("post-rst valid", 32'(bus.src_valid), 32'd0);
        bus.src_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
